ex_mult_pool: RTL and testbench
===============================

// Module: ex_mult_pool
// PURPOSE
//  Parametrised pool of NUM_UNITS independent pipelined RV32M multipliers for the execute stage.
//  Issue logic selects a free unit by index. Each unit computes MUL/MULH/MULHSU/MULHU over STAGES cycles.
//  A finished result is held in its unit until the completion bus accepts it.
//  A round-robin arbiter drives one result per cycle onto a valid/ready completion port.
// PARAMETERS
//  NUM_UNITS  2   number of multiplier units (>=1)
//  STAGES     4   pipeline depth per unit; XLEN % STAGES == 0 (XLEN/STAGES multiplier bits per stage)
//  TAG_W      5   width of destination tag carried with each op
// PORTS
//  clock          in   1                      system clock
//  reset          in   1                      synchronous, active-high
//  issue_valid    in   1                      issue an op this cycle
//  issue_index    in   $clog2(NUM_UNITS)      target unit (must be free)
//  issue_func     in   MULT_FUNC              MUL / MULH / MULHSU / MULHU
//  issue_opa      in   XLEN                   rs1 value
//  issue_opb      in   XLEN                   rs2 value
//  issue_tag      in   TAG_W                  destination tag
//  free           out  NUM_UNITS              bit i = unit i idle and accepts issue
//  done_valid     out  1                      a finished result is presented
//  done_ready     in   1                      completion bus accepts this cycle
//  done_packet    out  MULT_DONE_PACKET       {result, tag, unit}
//  squash         in   1                      (MULT_SQUASH_EN only) flush all in-flight ops
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset: all units IDLE, free = all ones, done_valid = 0, done_packet = 0, RR pointer = 0.
//  - Unit FSM: IDLE -> BUSY (issue edge, stage cnt = 0) -> cnt++ each edge -> DONE when cnt == STAGES-1 -> IDLE on edge where granted & done_ready.
//  - Latency: issue sampled at edge N; done_valid can first be high after edge N+STAGES.
//  - free[i] = (state == IDLE), decoded from registers. It falls the cycle after issue and rises the cycle after acceptance.
//  - Issue to a non-free unit is ignored and flagged by an assertion. issue_index >= NUM_UNITS is ignored.
//  - Arithmetic: sign/zero-extend operands to XLEN+1 by func. MUL/MULH sign-extend both; MULHSU signs opa only; MULHU signs neither.
//    Product is 2*XLEN+2 bits, accumulated as partial products per stage. MUL returns [XLEN-1:0]; others return [2XLEN-1:XLEN].
//  - Arbiter: among DONE units, grant the first index at or after (ptr+1) mod NUM_UNITS.
//    The grant locks while done_valid & !done_ready, so done_packet is stable until accepted.
//    On acceptance ptr <= granted index.
//  - Simultaneous completions: all extra DONE units hold their results. No result is dropped or reordered within a unit.
//  - Acceptance and a new issue to the same unit in the same cycle are not possible (free low in DONE).
//  - Reset mid-operation discards all in-flight ops. No done_valid is produced for them.
// CONFIGURATION
//  MULT_SQUASH_EN defined:
//   - squash port exists.
//   - A squash sampled at an edge forces every unit to IDLE, drops any issue in that cycle, and deasserts done_valid next cycle. RR pointer is kept.
//  MULT_SQUASH_EN undefined:
//   - No squash port. Ops always run to completion.
// STRUCTURE
//  - sys_defs.svh: MULT_FUNC enum and MULT_DONE_PACKET struct {result, tag, unit}.
//  - Sub-module mult_pipe_unit: one unit with FSM, stage counter, partial-product regs and held result.
//  - This module holds NUM_UNITS instances, the RR arbiter and the output mux.
// TESTING
//  1. reset; MUL opa=2 opb=3 to unit0 -> free[0]=0 next cycle; done_valid after 4 cycles; result=6, tag echoed.
//  2. MULH 123456789*123456789 -> 0x00362622.
//     MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU opa=-1 opb=0xFFFFFFFF -> 0xFFFFFFFF.
//     MUL -1*-1 -> 1.
//  3. Same-cycle issue to unit0 (6*3) and unit1 (10*11); hold done_ready=0 for 3 cycles.
//     Expect done_packet stable (unit0, 18); then ready=1 -> 18 then 110 on consecutive cycles.
//     free[0] rises before free[1].
//  4. Issue to busy unit0 while it computes -> ignored; unit0 result unchanged, assertion fires.
//  5. Reset asserted 2 cycles after issue -> free all ones, done_valid=0, no stale result.
//  6. (MULT_SQUASH_EN) squash with both units BUSY plus a same-cycle issue
//     -> next cycle free=2'b11, done_valid=0; new 4*5 afterwards -> 20.

Source files
------------

// File: rtl/ex_mult_pool_pkg.sv
// Shared types for the execute-stage multiplier pool.
//   XLEN               datapath width
//   MULT_TAG_W         destination-tag width carried in the completion packet
//   MULT_UNIT_W        unit-index width carried in the completion packet
//   mult_func_t        MUL / MULH / MULHSU / MULHU
//   unit_state_t       per-unit FSM state
//   mult_done_packet_t {result, tag, unit} presented on the completion port
package ex_mult_pool_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned MULT_TAG_W  = 5;
   localparam int unsigned MULT_UNIT_W = 4;

   typedef enum logic [1:0] {
      MULT_MUL    = 2'd0,
      MULT_MULH   = 2'd1,
      MULT_MULHSU = 2'd2,
      MULT_MULHU  = 2'd3
   } mult_func_t;

   typedef enum logic [1:0] {
      UNIT_IDLE = 2'd0,
      UNIT_BUSY = 2'd1,
      UNIT_DONE = 2'd2
   } unit_state_t;

   typedef struct packed {
      logic [XLEN-1:0]        result;
      logic [MULT_TAG_W-1:0]  tag;
      logic [MULT_UNIT_W-1:0] unit;
   } mult_done_packet_t;

   // rs1 is treated as signed for every function except MULHU
   function automatic logic opa_is_signed(input mult_func_t f);
      return (f != MULT_MULHU);
   endfunction

   // rs2 is treated as signed only for MUL and MULH
   function automatic logic opb_is_signed(input mult_func_t f);
      return (f == MULT_MUL) || (f == MULT_MULH);
   endfunction

endpackage

// File: rtl/ex_mult_pool_mult_pipe_unit.sv
// One pipelined multiplier unit: IDLE -> BUSY (STAGES partial-product steps) -> DONE,
// holding its result until the completion port accepts it.
//   clock, reset  clock and synchronous active-high reset
//   flush         return to IDLE immediately, discarding the op
//   start         accept an op (only acted on in IDLE)
//   func/opa/opb/tag_in  op payload
//   accept        result taken by the completion port this cycle
//   idle, done    decoded FSM state
//   result, tag   held result and tag of the finished op
module mult_pipe_unit
   import ex_mult_pool_pkg::*;
#(
   parameter int unsigned STAGES = 4,
   parameter int unsigned TAG_W  = MULT_TAG_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             start,
   input  mult_func_t       func,
   input  logic [XLEN-1:0]  opa,
   input  logic [XLEN-1:0]  opb,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             accept,
   output logic             idle,
   output logic             done,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] tag
);

   localparam int unsigned CHUNK = XLEN / STAGES;
   localparam int unsigned PW    = 2 * XLEN + 2;
   localparam int unsigned CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam int unsigned SH_W  = $clog2(XLEN + 1);

   unit_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN:0]    a_q;
   logic [XLEN:0]    b_q;
   logic [PW-1:0]    acc_q;
   mult_func_t       func_q;
   logic [XLEN-1:0]  result_q;
   logic [TAG_W-1:0] tag_q;

   logic             last;
   logic [SH_W-1:0]  shamt;
   logic [CHUNK-1:0] chunk;
   logic [PW-1:0]    a_ext;
   logic [PW-1:0]    pp;
   logic [PW-1:0]    corr;
   logic [PW-1:0]    acc_next;
   logic [XLEN-1:0]  res_next;

   // One CHUNK-bit slice of rs2 per stage; the extended sign bit of rs2 carries weight
   // -2^XLEN, so it is folded in as a subtraction on the final stage.
   always_comb begin
      last     = (cnt_q == CNT_W'(STAGES - 1));
      shamt    = SH_W'(cnt_q) * SH_W'(CHUNK);
      chunk    = b_q[shamt +: CHUNK];
      a_ext    = {{(PW - XLEN - 1){a_q[XLEN]}}, a_q};
      pp       = (a_ext * PW'(chunk)) << shamt;
      corr     = (last && b_q[XLEN]) ? (a_ext << XLEN) : '0;
      acc_next = acc_q + pp - corr;
      res_next = (func_q == MULT_MUL) ? acc_next[XLEN-1:0] : acc_next[2*XLEN-1:XLEN];
   end

   // Unit FSM with stage counter and datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= UNIT_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         func_q   <= MULT_MUL;
         result_q <= '0;
         tag_q    <= '0;
      end else if (flush) begin
         state_q <= UNIT_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            UNIT_IDLE: begin
               if (start) begin
                  state_q <= UNIT_BUSY;
                  cnt_q   <= '0;
                  a_q     <= {opa_is_signed(func) & opa[XLEN-1], opa};
                  b_q     <= {opb_is_signed(func) & opb[XLEN-1], opb};
                  acc_q   <= '0;
                  func_q  <= func;
                  tag_q   <= tag_in;
               end
            end
            UNIT_BUSY: begin
               acc_q <= acc_next;
               cnt_q <= cnt_q + CNT_W'(1);
               if (last) begin
                  state_q  <= UNIT_DONE;
                  result_q <= res_next;
               end
            end
            UNIT_DONE: begin
               if (accept) state_q <= UNIT_IDLE;
            end
            default: state_q <= UNIT_IDLE;
         endcase
      end
   end

   assign idle   = (state_q == UNIT_IDLE);
   assign done   = (state_q == UNIT_DONE);
   assign result = result_q;
   assign tag    = tag_q;

endmodule

// File: rtl/ex_mult_pool.sv
// Pool of NUM_UNITS pipelined RV32M multipliers with a round-robin valid/ready completion port.
// Optional feature macro: MULT_SQUASH_EN adds the squash port (flush all in-flight ops).
//   clock, reset       clock and synchronous active-high reset
//   issue_*            op issue to unit issue_index (ignored if that unit is not free)
//   free               bit i set when unit i is idle
//   done_valid/ready   completion handshake
//   done_packet        {result, tag, unit} of the granted unit, zero when nothing is done
//   squash             (MULT_SQUASH_EN) return every unit to idle
module ex_mult_pool
   import ex_mult_pool_pkg::*;
#(
   parameter  int unsigned NUM_UNITS = 2,
   parameter  int unsigned STAGES    = 4,
   parameter  int unsigned TAG_W     = MULT_TAG_W,
   localparam int unsigned IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [IDX_W-1:0]  issue_index,
   input  mult_func_t        issue_func,
   input  logic [XLEN-1:0]   issue_opa,
   input  logic [XLEN-1:0]   issue_opb,
   input  logic [TAG_W-1:0]  issue_tag,
   output logic [NUM_UNITS-1:0] free,
   output logic              done_valid,
   input  logic              done_ready,
   output mult_done_packet_t done_packet
`ifdef MULT_SQUASH_EN
   ,
   input  logic              squash
`endif
);

   logic                 flush;
   logic [NUM_UNITS-1:0] done_vec;
   logic [XLEN-1:0]      unit_result [NUM_UNITS];
   logic [TAG_W-1:0]     unit_tag    [NUM_UNITS];

   logic [IDX_W-1:0]     ptr_q;
   logic                 lock_q;
   logic [IDX_W-1:0]     lock_idx_q;
   logic [IDX_W-1:0]     pick;
   logic [IDX_W-1:0]     cand;
   logic                 found;
   logic [IDX_W-1:0]     grant;

`ifdef MULT_SQUASH_EN
   assign flush = squash;
`else
   assign flush = 1'b0;
`endif

   // Multiplier units; an issue to a unit that is not idle never reaches it
   for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
      mult_pipe_unit #(
         .STAGES (STAGES),
         .TAG_W  (TAG_W)
      ) u_unit (
         .clock  (clock),
         .reset  (reset),
         .flush  (flush),
         .start  (issue_valid && !flush && (issue_index == IDX_W'(i))),
         .func   (issue_func),
         .opa    (issue_opa),
         .opb    (issue_opb),
         .tag_in (issue_tag),
         .accept (done_valid && done_ready && (grant == IDX_W'(i))),
         .idle   (free[i]),
         .done   (done_vec[i]),
         .result (unit_result[i]),
         .tag    (unit_tag[i])
      );
   end

   // Round-robin pick starting after the last accepted unit; a stalled grant stays locked
   always_comb begin
      pick  = ptr_q;
      cand  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_UNITS; k++) begin
         cand = IDX_W'((32'(ptr_q) + k) % NUM_UNITS);
         if (!found && done_vec[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      grant = lock_q ? lock_idx_q : pick;
   end

   assign done_valid = |done_vec;

   // Output mux of the granted unit
   always_comb begin
      done_packet = '0;
      if (done_valid) begin
         done_packet.result = unit_result[grant];
         done_packet.tag    = MULT_TAG_W'(unit_tag[grant]);
         done_packet.unit   = MULT_UNIT_W'(grant);
      end
   end

   // Arbiter pointer and grant lock; squash clears the lock but keeps the pointer
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (flush) begin
         lock_q <= 1'b0;
      end else begin
         lock_q     <= done_valid && !done_ready;
         lock_idx_q <= grant;
         if (done_valid && done_ready) ptr_q <= grant;
      end
   end

   // Issuing to an occupied unit is a scheduler bug upstream
   always_ff @(posedge clock) begin
      if (!reset && !flush && issue_valid && (32'(issue_index) < NUM_UNITS)) begin
         assert (free[issue_index])
         else $warning("ex_mult_pool: issue to occupied unit %0d ignored", issue_index);
      end
   end

endmodule

// File: tb/tb_ex_mult_pool.sv
// Self-checking bench for ex_mult_pool: vector table, random ops against a reference
// model, and directed sequences for stalls, busy issue, reset and (optionally) squash.
module tb_ex_mult_pool;
   import ex_mult_pool_pkg::*;

   localparam int unsigned NUM_UNITS = 2;
   localparam int unsigned STAGES    = 4;
   localparam int unsigned TAG_W     = 5;
   localparam int unsigned IDX_W     = 1;
   localparam int unsigned NVEC      = 10;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 issue_valid;
   logic [IDX_W-1:0]     issue_index;
   mult_func_t           issue_func;
   logic [31:0]          issue_opa;
   logic [31:0]          issue_opb;
   logic [TAG_W-1:0]     issue_tag;
   logic [NUM_UNITS-1:0] free;
   logic                 done_valid;
   logic                 done_ready;
   mult_done_packet_t    done_packet;
`ifdef MULT_SQUASH_EN
   logic                 squash;
`endif

   always #5 clock = ~clock;

   ex_mult_pool #(
      .NUM_UNITS (NUM_UNITS),
      .STAGES    (STAGES),
      .TAG_W     (TAG_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_index (issue_index),
      .issue_func  (issue_func),
      .issue_opa   (issue_opa),
      .issue_opb   (issue_opb),
      .issue_tag   (issue_tag),
      .free        (free),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .done_packet (done_packet)
`ifdef MULT_SQUASH_EN
      ,
      .squash      (squash)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   mult_done_packet_t sb[$];
   mult_done_packet_t mon_exp;

   typedef struct {
      mult_func_t  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic mult_done_packet_t mk(input logic [31:0] r, input logic [4:0] t, input int u);
      mult_done_packet_t p;
      p.result = r;
      p.tag    = t;
      p.unit   = 4'(u);
      return p;
   endfunction

   // Reference: sign/zero-extend to 66 bits and take the modular product
   function automatic logic [31:0] mul_ref(input mult_func_t f, input logic [31:0] a, input logic [31:0] b);
      logic [65:0] ae;
      logic [65:0] be;
      logic [65:0] p;
      ae = {{34{(f != MULT_MULHU) && a[31]}}, a};
      be = {{34{((f == MULT_MUL) || (f == MULT_MULH)) && b[31]}}, b};
      p  = ae * be;
      return (f == MULT_MUL) ? p[31:0] : p[63:32];
   endfunction

   // Scoreboard: every accepted result must be the oldest expected one
   always @(negedge clock) begin
      if (!reset && done_valid && done_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got 0x%0h with no result expected", done_packet);
         end else begin
            mon_exp = sb.pop_front();
            check("done_packet", 64'(done_packet), 64'(mon_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_issue(input int idx, input mult_func_t f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] t,
                           input bit expect_it, input logic [31:0] exp);
      issue_valid = 1'b1;
      issue_index = IDX_W'(idx);
      issue_func  = f;
      issue_opa   = a;
      issue_opb   = b;
      issue_tag   = t;
      if (expect_it) sb.push_back(mk(exp, t, idx));
      tick();
      issue_valid = 1'b0;
   endtask

   // Run until all units are idle and every expected result was taken
   task automatic wait_idle(input string name, input bit rand_ready);
      int n;
      n = 0;
      while (!((free == 2'b11) && (sb.size() == 0)) && (n < 100)) begin
         if (rand_ready) done_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      done_ready = 1'b1;
      check({name, " drain"}, 64'(n < 100), 64'd1);
   endtask

   initial begin
      int n;
      int hits;
      int u;
      mult_func_t f;
      logic [31:0] a;
      logic [31:0] b;

      reset       = 1'b1;
      issue_valid = 1'b0;
      issue_index = '0;
      issue_func  = MULT_MUL;
      issue_opa   = '0;
      issue_opb   = '0;
      issue_tag   = '0;
      done_ready  = 1'b1;
`ifdef MULT_SQUASH_EN
      squash      = 1'b0;
`endif

      vecs[0] = '{MULT_MULH,   32'd123456789, 32'd123456789, 32'h00362622};
      vecs[1] = '{MULT_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE};
      vecs[2] = '{MULT_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF};
      vecs[3] = '{MULT_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001};
      vecs[4] = '{MULT_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000};
      vecs[5] = '{MULT_MULH,   32'h80000000,  32'h80000000,  32'h40000000};
      vecs[6] = '{MULT_MULHSU, 32'h80000000,  32'hFFFFFFFF,  32'h80000000};
      vecs[7] = '{MULT_MULHU,  32'h80000000,  32'h00000002,  32'h00000001};
      vecs[8] = '{MULT_MUL,    32'h12345678,  32'h00000010,  32'h23456780};
      vecs[9] = '{MULT_MULH,   32'h00000007,  32'hFFFFFFFD,  32'hFFFFFFFF};

      repeat (3) tick();
      check("reset free", 64'(free), 64'h3);
      check("reset done_valid", 64'(done_valid), 64'd0);
      check("reset done_packet", 64'(done_packet), 64'd0);
      reset = 1'b0;

      // Basic MUL, latency and free timing
      do_issue(0, MULT_MUL, 32'd2, 32'd3, 5'd7, 1'b1, 32'd6);
      check("t1 free0 after issue", 64'(free[0]), 64'd0);
      check("t1 done_valid early", 64'(done_valid), 64'd0);
      repeat (3) tick();
      check("t1 done_valid before latency", 64'(done_valid), 64'd0);
      tick();
      check("t1 done_valid at latency", 64'(done_valid), 64'd1);
      check("t1 packet", 64'(done_packet), 64'(mk(32'd6, 5'd7, 0)));
      tick();
      check("t1 free after accept", 64'(free), 64'h3);

      // Vector table
      for (int i = 0; i < NVEC; i++) begin
         do_issue(i % 2, vecs[i].func, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1, vecs[i].exp);
         wait_idle("vec", 1'b0);
      end

      // Random ops with random completion back-pressure
      for (int i = 0; i < 8; i++) begin
         f = mult_func_t'(2'($urandom_range(0, 3)));
         a = $urandom();
         b = $urandom();
         u = int'($urandom_range(0, 1));
         do_issue(u, f, a, b, 5'(i + 16), 1'b1, mul_ref(f, a, b));
         wait_idle("rand", 1'b1);
      end

      // Two units finishing while the completion port stalls
      done_ready = 1'b0;
      do_issue(0, MULT_MUL, 32'd6, 32'd3, 5'd10, 1'b1, 32'd18);
      do_issue(1, MULT_MUL, 32'd10, 32'd11, 5'd11, 1'b1, 32'd110);
      n = 0;
      while (!done_valid && (n < 20)) begin
         tick();
         n++;
      end
      check("t3 first done seen", 64'(n < 20), 64'd1);
      for (int k = 0; k < 3; k++) begin
         check("t3 stall valid", 64'(done_valid), 64'd1);
         check("t3 stall packet", 64'(done_packet), 64'(mk(32'd18, 5'd10, 0)));
         if (k < 2) tick();
      end
      done_ready = 1'b1;
      tick();
      check("t3 free0 first", 64'(free), 64'h1);
      check("t3 second packet", 64'(done_packet), 64'(mk(32'd110, 5'd11, 1)));
      tick();
      check("t3 free1 next", 64'(free), 64'h3);

      // Issue to a busy unit is ignored
      do_issue(0, MULT_MUL, 32'd5, 32'd7, 5'd3, 1'b1, 32'd35);
      tick();
      do_issue(0, MULT_MUL, 32'd100, 32'd100, 5'd4, 1'b0, 32'd0);
      wait_idle("busy issue", 1'b0);

      // Reset in the middle of an op
      do_issue(1, MULT_MUL, 32'd9, 32'd9, 5'd9, 1'b0, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("t5 reset free", 64'(free), 64'h3);
      check("t5 reset done_valid", 64'(done_valid), 64'd0);
      check("t5 reset done_packet", 64'(done_packet), 64'd0);
      reset = 1'b0;
      hits = 0;
      repeat (8) begin
         tick();
         if (done_valid) hits++;
      end
      check("t5 no stale result", 64'(hits), 64'd0);

`ifdef MULT_SQUASH_EN
      // Squash with both units busy and a same-cycle issue
      do_issue(0, MULT_MUL, 32'd1, 32'd1, 5'd1, 1'b0, 32'd0);
      do_issue(1, MULT_MUL, 32'd2, 32'd2, 5'd2, 1'b0, 32'd0);
      squash = 1'b1;
      do_issue(0, MULT_MUL, 32'd3, 32'd3, 5'd3, 1'b0, 32'd0);
      squash = 1'b0;
      check("t6 squash free", 64'(free), 64'h3);
      check("t6 squash done_valid", 64'(done_valid), 64'd0);
      hits = 0;
      repeat (8) begin
         tick();
         if (done_valid) hits++;
      end
      check("t6 nothing after squash", 64'(hits), 64'd0);
      do_issue(0, MULT_MUL, 32'd4, 32'd5, 5'd6, 1'b1, 32'd20);
      wait_idle("t6 after squash", 1'b0);
`endif

      check("scoreboard empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
